pipeline_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Keeps shadow copies of the destination and source fields of instructions in flight, and produces stage-register enables, bubble/flush controls and EX-operand forwarding selects.
- Resolves three events: load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits.
- Sits beside the datapath and decodes opcodes with the common package's instruction_format_type; forwarding selects use forwarding_type.

---
 rtl/pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline: load-use stalls, redirect flushes, data-memory waits.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush/wait performance counter outputs.
package common;
  localparam logic RESET = 1'b0;

  typedef enum logic [6:0] {
    LOAD    = 7'b0000011,
    OP_IMM  = 7'b0010011,
    U_AUIPC = 7'b0010111,
    STORE   = 7'b0100011,
    OP      = 7'b0110011,
    U_LUI   = 7'b0110111,
    BRANCH  = 7'b1100011,
    JALR    = 7'b1100111,
    J_JAL   = 7'b1101111
  } instruction_format_type;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EX_MEM = 2'd1,
    MEM_WB = 2'd2
  } forwarding_type;
endpackage

module pipeline_hazard_ctrl
  import common::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output forwarding_type        fwd_a,
  output forwarding_type        fwd_b,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           wait_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  ld;
    logic                  mem;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rd_rs1;
    logic                  rd_rs2;
  } shadow_t;

  typedef enum logic {RUN, MEM_WAIT} state_e;

  shadow_t          id_entry;
  shadow_t          s_ex_q, s_mem_q, s_wb_q;
  state_e           state_q;
  logic [CNT_W-1:0] wait_q;
  logic             mem_timeout_q;
  logic             in_reset, mem_wait, load_use;
  logic             unused_bits;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path through the case infers a latch.
    id_entry       = '0;
    id_entry.valid = id_valid;
    id_entry.rd    = id_rd;
    id_entry.rs1   = id_rs1;
    id_entry.rs2   = id_rs2;
    case (id_opcode)
      OP:                     {id_entry.wr, id_entry.rd_rs1, id_entry.rd_rs2} = 3'b111;
      OP_IMM, JALR:           {id_entry.wr, id_entry.rd_rs1} = 2'b11;
      LOAD:                   {id_entry.wr, id_entry.ld, id_entry.mem, id_entry.rd_rs1} = 4'b1111;
      STORE:                  {id_entry.mem, id_entry.rd_rs1, id_entry.rd_rs2} = 3'b111;
      BRANCH:                 {id_entry.rd_rs1, id_entry.rd_rs2} = 2'b11;
      J_JAL, U_LUI, U_AUIPC:  id_entry.wr = 1'b1;
      default:                ;
    endcase
  end

  assign in_reset = (reset == RESET);
  assign mem_wait = s_mem_q.valid & s_mem_q.mem & ~mem_ready;
  assign load_use = s_ex_q.valid & s_ex_q.ld & (s_ex_q.rd != '0) & id_valid &
                    ((id_entry.rd_rs1 & (id_rs1 == s_ex_q.rd)) |
                     (id_entry.rd_rs2 & (id_rs2 == s_ex_q.rd)));

  // Memory wait outranks redirect, which outranks load-use: a squashed ID instruction cannot cause a stall.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!in_reset) begin
      if (mem_wait) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // A load in MEM has no data yet, so it may only forward once it reaches WB.
  function automatic forwarding_type fwd_sel(input shadow_t mem_e, input shadow_t wb_e,
                                             input logic [REG_ADDR_W-1:0] rs, input logic rd_rs);
    fwd_sel = NONE;
    if (mem_e.valid && mem_e.wr && !mem_e.ld && mem_e.rd != '0 && mem_e.rd == rs && rd_rs)
      fwd_sel = EX_MEM;
    else if (wb_e.valid && wb_e.wr && wb_e.rd != '0 && wb_e.rd == rs && rd_rs)
      fwd_sel = MEM_WB;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(s_mem_q, s_wb_q, s_ex_q.rs1, s_ex_q.rd_rs1);
    fwd_b = fwd_sel(s_mem_q, s_wb_q, s_ex_q.rs2, s_ex_q.rd_rs2);
  end

  // NOTE: the shadows are flops rather than a RAM and must take the async reset; valid=0 stops stale fields forwarding.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET) begin
      s_ex_q        <= '0;
      s_mem_q       <= '0;
      s_wb_q        <= '0;
      state_q       <= RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's pre-edge value, like real pipeline registers.
      if (id_ex_en)  s_ex_q  <= (id_ex_flush || !id_valid) ? '0 : id_entry;
      if (ex_mem_en) s_mem_q <= s_ex_q;
      if (mem_wb_en) s_wb_q  <= s_mem_q;

      state_q <= mem_wait ? MEM_WAIT : RUN;
      if (mem_wait) begin
        if (wait_q != CNT_W'(MEM_WAIT_MAX)) wait_q <= wait_q + CNT_W'(1);
        if (wait_q >= CNT_W'(MEM_WAIT_MAX - 1)) mem_timeout_q <= 1'b1;
      end else if (state_q == MEM_WAIT) begin
        wait_q <= '0;
      end
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (mem_wait)                    wait_cnt_q  <= wait_cnt_q + 32'd1;
      else if (ex_redirect)            flush_cnt_q <= flush_cnt_q + 32'd1;
      else if (load_use)               stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

  // Not every shadow field is consumed in every stage.
  assign unused_bits = ^{s_ex_q, s_mem_q, s_wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan scenarios plus random stimulus vs. an instruction-level model.
module tb_pipeline_hazard_ctrl;
  localparam int WAIT_MAX = 15;
  localparam bit [6:0] O_OP = 7'h33, O_IMM = 7'h13, O_LD = 7'h03, O_ST = 7'h23, O_BR = 7'h63,
                       O_JALR = 7'h67, O_JAL = 7'h6f, O_LUI = 7'h37, O_AUIPC = 7'h17, O_FENCE = 7'h0f;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       ex_redirect = 1'b0, mem_ready = 1'b1;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction-level model: raw instructions in EX/MEM/WB, decoded from the opcode when needed.
  typedef struct {
    bit       v;
    bit [6:0] op;
    bit [4:0] rd, rs1, rs2;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  int     m_wait_run;
  bit     m_to, m_rst;
  int     m_stalls, m_flushes, m_waits;
  bit     e_wait, e_redir, e_lu;
  bit     e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl_ifid, e_fl_idex;
  int     n_tests = 0, n_fail = 0;

  function automatic bit f_writes(bit [6:0] op);
    return op inside {O_OP, O_IMM, O_LD, O_JALR, O_JAL, O_LUI, O_AUIPC};
  endfunction
  function automatic bit f_reads1(bit [6:0] op);
    return op inside {O_OP, O_IMM, O_LD, O_ST, O_BR, O_JALR};
  endfunction
  function automatic bit f_reads2(bit [6:0] op);
    return op inside {O_OP, O_ST, O_BR};
  endfunction

  // Most recent older producer wins; a load still in MEM cannot supply its value.
  function automatic int f_fwd(bit [4:0] rs, bit uses);
    if (!uses || rs == 5'd0) return 0;
    if (m_mem.v && f_writes(m_mem.op) && m_mem.op != O_LD && m_mem.rd == rs) return 1;
    if (m_wb.v && f_writes(m_wb.op) && m_wb.rd == rs) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_ex = '{default: 0};
    m_mem = '{default: 0};
    m_wb = '{default: 0};
    m_wait_run = 0;
    m_to = 0;
    m_stalls = 0;
    m_flushes = 0;
    m_waits = 0;
  endtask

  task automatic compare();
    e_wait  = m_mem.v && (m_mem.op == O_LD || m_mem.op == O_ST) && !mem_ready;
    e_redir = ex_redirect;
    e_lu    = m_ex.v && m_ex.op == O_LD && m_ex.rd != 0 && id_valid &&
              ((f_reads1(id_opcode) && id_rs1 == m_ex.rd) || (f_reads2(id_opcode) && id_rs2 == m_ex.rd));
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl_ifid, e_fl_idex} = 7'b11111_00;
    if (!m_rst) begin
      if (e_wait)       {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b0;
      else if (e_redir) {e_fl_ifid, e_fl_idex} = 2'b11;
      else if (e_lu)    {e_pc, e_ifid, e_fl_idex} = 3'b001;
    end
    check("pc_en", pc_en, e_pc);
    check("if_id_en", if_id_en, e_ifid);
    check("id_ex_en", id_ex_en, e_idex);
    check("ex_mem_en", ex_mem_en, e_exmem);
    check("mem_wb_en", mem_wb_en, e_memwb);
    check("if_id_flush", if_id_flush, e_fl_ifid);
    check("id_ex_flush", id_ex_flush, e_fl_idex);
    check("fwd_a", fwd_a, f_fwd(m_ex.rs1, m_ex.v && f_reads1(m_ex.op)));
    check("fwd_b", fwd_b, f_fwd(m_ex.rs2, m_ex.v && f_reads2(m_ex.op)));
    check("mem_timeout", mem_timeout, m_to);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
    check("wait_cnt", wait_cnt, m_waits);
`endif
  endtask

  // Called at a falling edge: apply inputs, then compare away from the rising edge.
  task automatic drive(input bit v, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit redir, input bit rdy);
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_redirect = redir; mem_ready = rdy;
    #1 compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!m_rst) begin
      if (e_wait) begin
        m_wait_run++;
        m_waits++;
        if (m_wait_run >= WAIT_MAX) m_to = 1;
      end else begin
        m_wait_run = 0;
        if (e_redir) m_flushes++;
        else if (e_lu) m_stalls++;
        m_wb  = m_mem;
        m_mem = m_ex;
        if (e_fl_idex || !id_valid) m_ex = '{default: 0};
        else m_ex = '{v: 1, op: id_opcode, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      end
    end
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 7'h00, 0, 0, 0, 0, 1);
    tick();
  endtask

  bit [6:0] ops [10] = '{O_OP, O_IMM, O_LD, O_ST, O_BR, O_JALR, O_JAL, O_LUI, O_AUIPC, O_FENCE};

  initial begin
    m_clear();
    m_rst = 1;
    // Reset values hold even with a redirect and a memory stall pending on the inputs.
    drive(1, O_OP, 3, 1, 2, 1, 0);
    check("rst_pc_en", pc_en, 1);
    check("rst_flush", {if_id_flush, id_ex_flush}, 0);
    check("rst_fwd", {fwd_a, fwd_b}, 0);
    check("rst_timeout", mem_timeout, 0);
    tick();
    reset = 1'b1;
    m_rst = 0;

    // LW x5 then ADD x6,x5,x1: one bubble, then MEM_WB forwarding.
    drive(1, O_LD, 5, 1, 0, 0, 1); tick();
    drive(1, O_OP, 6, 5, 1, 0, 1);
    check("lu_stall", {pc_en, if_id_en, id_ex_en, id_ex_flush}, 4'b0011);
    tick();
    drive(1, O_OP, 6, 5, 1, 0, 1);
    check("lu_release", {pc_en, if_id_en, id_ex_flush}, 3'b110);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("lu_fwd_a", fwd_a, 2);
    check("lu_fwd_b", fwd_b, 0);
    tick();

    // ADD x3,x1,x2 then SUB x4,x3,x3: EX_MEM on both operands.
    drive(1, O_OP, 3, 1, 2, 0, 1); tick();
    drive(1, O_OP, 4, 3, 3, 0, 1);
    check("alu_no_stall", pc_en, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("alu_fwd", {fwd_a, fwd_b}, 4'b0101);
    tick();

    // Writes to x0 never forward.
    drive(1, O_IMM, 0, 0, 0, 0, 1); tick();
    drive(1, O_OP, 7, 0, 0, 0, 1);
    check("x0_no_stall", pc_en, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("x0_fwd", {fwd_a, fwd_b}, 0);
    tick();

    // Redirect beats a simultaneous load-use.
    drive(1, O_LD, 5, 1, 0, 0, 1); tick();
    drive(1, O_OP, 6, 5, 1, 1, 1);
    check("redir_flush", {if_id_flush, id_ex_flush}, 2'b11);
    check("redir_en", {pc_en, if_id_en}, 2'b11);
    tick();
    nop();

    // SW in MEM, 3 wait cycles; shadows and forwarding hold.
    drive(1, O_IMM, 9, 0, 0, 0, 1); tick();
    drive(1, O_ST, 0, 1, 2, 0, 1); tick();
    drive(1, O_OP, 8, 9, 9, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check("wait_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
      check("wait_fwd", {fwd_a, fwd_b}, 4'b1010);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    check("wait_done_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    check("wait_done_fwd", {fwd_a, fwd_b}, 4'b1010);
    tick();
    nop();

    // 20-cycle wait: timeout after 15 wait cycles, sticky, then async reset mid-wait.
    drive(1, O_ST, 0, 1, 2, 0, 1); tick();
    nop();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (i == 14) check("to_before", mem_timeout, 0);
      if (i == 15) check("to_rise", mem_timeout, 1);
      if (i == 19) check("to_sticky", mem_timeout, 1);
      if (i < 19) tick();
    end
    ex_redirect = 1;
    #2 reset = 1'b0;
    m_clear();
    m_rst = 1;
    #1 compare();
    check("async_rst_timeout", mem_timeout, 0);
    check("async_rst_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    check("async_rst_flush", {if_id_flush, id_ex_flush}, 0);
    @(negedge clk);
    reset = 1'b1;
    m_rst = 0;

    // Random traffic: small register range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(7) != 0, ops[$urandom_range(9)], 5'($urandom_range(3)),
            5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(7) == 0,
            $urandom_range(3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
